// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: clears the register file after reset, then runs one
// instruction at a time through the shared register-file / ALU datapath.
`default_nettype none

module rf_alu_sequencer #(
  parameter int NREG    = 32,
  parameter int INIT_EN = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_op,
  input  logic [4:0]  instr_rd,
  input  logic [4:0]  instr_rs1,
  input  logic [4:0]  instr_rs2,
  input  logic [31:0] instr_imm,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3,
  output logic [1:0]  opcode,
  input  logic [31:0] ALU_result,
  output logic [31:0] result,
  output logic        done,
  output logic        err,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam state_t     RST_STATE = (INIT_EN != 0) ? S_INIT : S_IDLE;
  localparam logic [4:0] LAST_REG  = 5'(NREG - 1);
  localparam logic [2:0] OP_LI     = 3'd4;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q, hold_q, result_q;
  logic        init_done_q;

  // Address/data/opcode outputs keep their last driven value between uses.
  logic [4:0]  a1_q, a2_q, a3_q, a1_d, a2_d, a3_d;
  logic [31:0] wd3_q, wd3_d;
  logic [1:0]  opc_q, opc_d;
  logic        we, dn, er, rdy;
  logic        accept;

  assign accept = (state == S_IDLE) && instr_valid;

  always_comb begin
    state_nxt = state;
    a1_d      = a1_q;
    a2_d      = a2_q;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    opc_d     = opc_q;
    we        = 1'b0;
    dn        = 1'b0;
    er        = 1'b0;
    rdy       = 1'b0;
    case (state)
      S_INIT: begin
        we    = 1'b1;
        a3_d  = cnt;
        wd3_d = '0;
        if (cnt == LAST_REG) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        rdy = 1'b1;
        if (instr_valid) begin
          if (instr_op <= 3'd3)      state_nxt = S_EXEC;
          else if (instr_op == OP_LI) state_nxt = S_WB;
          else                        state_nxt = S_ERR;
        end
      end
      S_EXEC: begin
        a1_d      = rs1_q;
        a2_d      = rs2_q;
        opc_d     = op_q[1:0];
        state_nxt = S_WB;
      end
      S_WB: begin
        we        = 1'b1;
        dn        = 1'b1;
        a3_d      = rd_q;
        wd3_d     = (op_q == OP_LI) ? imm_q : hold_q;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        er        = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Reset forces every output low at once, not just at the next edge.
  assign instr_ready = rdy & ~RST;
  assign WE3         = we  & ~RST;
  assign done        = dn  & ~RST;
  assign err         = er  & ~RST;
  assign A1          = RST ? 5'd0  : a1_d;
  assign A2          = RST ? 5'd0  : a2_d;
  assign A3          = RST ? 5'd0  : a3_d;
  assign WD3         = RST ? 32'd0 : wd3_d;
  assign opcode      = RST ? 2'd0  : opc_d;
  assign result      = result_q;
  assign init_done   = init_done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RST_STATE;
      cnt         <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      hold_q      <= '0;
      result_q    <= '0;
      init_done_q <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      wd3_q       <= '0;
      opc_q       <= '0;
    end else begin
      state <= state_nxt;
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      opc_q <= opc_d;
      if (state == S_INIT) begin
        cnt <= cnt + 5'd1;
        if (cnt == LAST_REG) init_done_q <= 1'b1;
      end
      if (accept) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        imm_q <= instr_imm;
      end
      if (state == S_EXEC) hold_q   <= ALU_result;
      if (state == S_WB)   result_q <= wd3_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench: sequencer driving a behavioural register file and ALU,
// plus a second instance with the clear sequence disabled.
`default_nettype none

module tb_rf_alu_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = '0;
  logic [4:0]  instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [31:0] instr_imm = '0;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3, ALU_result, result;
  logic        WE3, done, err, init_done;
  logic [1:0]  opcode;

  logic        b_rst = 1'b1;
  logic        b_valid = 1'b0;
  logic        b_ready, b_we, b_done, b_err, b_init_done;
  logic [4:0]  b_a1, b_a2, b_a3;
  logic [31:0] b_wd, b_result, b_alu;
  logic [1:0]  b_opc;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf  [32];
  logic [31:0] rf2 [32];
  logic [31:0] rd1, rd2;

  always #5 CLK = ~CLK;

  rf_alu_sequencer #(.NREG(32), .INIT_EN(1)) u_dut (
    .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .WE3(WE3), .opcode(opcode), .ALU_result(ALU_result),
    .result(result), .done(done), .err(err), .init_done(init_done)
  );

  rf_alu_sequencer #(.NREG(4), .INIT_EN(0)) u_dut_noinit (
    .CLK(CLK), .RST(b_rst), .instr_valid(b_valid), .instr_ready(b_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm), .A1(b_a1), .A2(b_a2), .A3(b_a3),
    .WD3(b_wd), .WE3(b_we), .opcode(b_opc), .ALU_result(b_alu),
    .result(b_result), .done(b_done), .err(b_err), .init_done(b_init_done)
  );

  // Register files are pre-filled with junk so the clear sequence is visible.
  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'hA5A5_0000 + i;
      rf2[i] = 32'h5A5A_0000 + i;
    end
  end

  always @(posedge CLK) begin
    if (WE3)  rf[A3]    <= WD3;
    if (b_we) rf2[b_a3] <= b_wd;
  end

  // Reference ALU: shift counts use the whole RD2 value.
  always_comb begin
    rd1 = rf[A1];
    rd2 = rf[A2];
    case (opcode)
      2'd0: ALU_result = rd1 + rd2;
      2'd1: ALU_result = rd1 - rd2;
      2'd2: ALU_result = (rd2 >= 32) ? 32'd0 : (rd1 << rd2[4:0]);
      default: ALU_result = (rd2 >= 32) ? 32'd0 : (rd1 >> rd2[4:0]);
    endcase
  end
  assign b_alu = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns 1 ns after the handshake edge.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    n = 0;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1 instr_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] exp);
    send(op, rd, rs1, rs2, 32'd0);
    @(negedge CLK);
    check({tag, "_exec_done"}, {31'd0, done}, 32'd0);
    check({tag, "_exec_we"}, {31'd0, WE3}, 32'd0);
    @(negedge CLK);
    check({tag, "_wb_done"}, {31'd0, done}, 32'd1);
    check({tag, "_wb_we"}, {31'd0, WE3}, 32'd1);
    check({tag, "_wb_a3"}, {27'd0, A3}, {27'd0, rd});
    check({tag, "_wb_wd3"}, WD3, exp);
    @(negedge CLK);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic run_li(input string tag, input logic [4:0] rd, input logic [31:0] imm);
    send(3'd4, rd, 5'd0, 5'd0, imm);
    @(negedge CLK);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_a3"}, {27'd0, A3}, {27'd0, rd});
    check({tag, "_wd3"}, WD3, imm);
    @(negedge CLK);
    check({tag, "_result"}, result, imm);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_we", {31'd0, WE3}, 32'd0);
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_result", result, 32'd0);
    RST = 1'b0;

    // Clear sequence: 32 consecutive writes of zero to r0..r31
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      check("init_we", {31'd0, WE3}, 32'd1);
      check("init_a3", {27'd0, A3}, i);
      check("init_wd3", WD3, 32'd0);
      check("init_ready", {31'd0, instr_ready}, 32'd0);
    end
    @(negedge CLK);
    check("init_done", {31'd0, init_done}, 32'd1);
    check("idle_ready", {31'd0, instr_ready}, 32'd1);
    check("idle_we", {31'd0, WE3}, 32'd0);
    check("rf0_clear", rf[0], 32'd0);
    check("rf17_clear", rf[17], 32'd0);
    check("rf31_clear", rf[31], 32'd0);

    // Basic datapath
    run_li("li_r1", 5'd1, 32'd7);
    run_li("li_r2", 5'd2, 32'd3);
    run_alu("add_r3", 3'd0, 5'd3, 5'd1, 5'd2, 32'd10);
    run_alu("sub_r4", 3'd1, 5'd4, 5'd2, 5'd1, 32'hFFFF_FFFC);
    run_alu("sll_r5", 3'd2, 5'd5, 5'd1, 5'd2, 32'd56);
    run_alu("srl_r6", 3'd3, 5'd6, 5'd5, 5'd2, 32'd7);
    check("rf3", rf[3], 32'd10);
    // Read-before-write with rd = rs1 = rs2, and a shift count of 40
    run_alu("sub_self", 3'd1, 5'd5, 5'd5, 5'd5, 32'd0);
    run_li("li_r8", 5'd8, 32'd40);
    run_alu("sll_big", 3'd2, 5'd9, 5'd1, 5'd8, 32'd0);

    // Illegal op with instr_valid held high across consecutive instructions
    instr_op = 3'd6; instr_rd = 5'd12; instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr_op = 3'd4; instr_rd = 5'd10; instr_imm = 32'h55;
    @(negedge CLK);
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_we", {31'd0, WE3}, 32'd0);
    check("err_ready", {31'd0, instr_ready}, 32'd0);
    check("err_result", result, 32'd0);
    @(negedge CLK);
    check("err_back_idle", {31'd0, instr_ready}, 32'd1);
    check("err_cleared", {31'd0, err}, 32'd0);
    @(posedge CLK);
    #1;
    instr_op = 3'd0; instr_rd = 5'd11; instr_rs1 = 5'd10; instr_rs2 = 5'd1;
    @(negedge CLK);
    check("held_li_done", {31'd0, done}, 32'd1);
    check("held_li_wd3", WD3, 32'h55);
    @(negedge CLK);
    check("held_idle_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge CLK);
    #1 instr_valid = 1'b0;
    @(negedge CLK);
    check("held_exec_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge CLK);
    check("held_add_wd3", WD3, 32'h5C);
    @(negedge CLK);
    check("held_add_result", result, 32'h5C);
    check("rf12_untouched", rf[12], 32'd0);

    // Reset during EXEC
    send(3'd0, 5'd7, 5'd1, 5'd2, 32'd0);
    #2 RST = 1'b1;
    #1;
    check("midrst_we", {31'd0, WE3}, 32'd0);
    check("midrst_a1", {27'd0, A1}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_init_done", {31'd0, init_done}, 32'd0);
    @(negedge CLK);
    check("midrst_we_hold", {31'd0, WE3}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (33) @(negedge CLK);
    check("reinit_done", {31'd0, init_done}, 32'd1);
    check("reinit_r7", rf[7], 32'd0);
    check("reinit_r1", rf[1], 32'd0);

    // Instance without the clear sequence
    @(posedge CLK);
    #1 b_rst = 1'b0;
    @(negedge CLK);
    check("noinit_ready", {31'd0, b_ready}, 32'd1);
    check("noinit_we", {31'd0, b_we}, 32'd0);
    instr_op = 3'd4; instr_rd = 5'd31; instr_imm = 32'hDEAD_BEEF; b_valid = 1'b1;
    @(posedge CLK);
    #1 b_valid = 1'b0;
    @(negedge CLK);
    check("noinit_done", {31'd0, b_done}, 32'd1);
    check("noinit_a3", {27'd0, b_a3}, 32'd31);
    @(negedge CLK);
    check("noinit_result", b_result, 32'hDEAD_BEEF);
    check("noinit_r31", rf2[31], 32'hDEAD_BEEF);
    check("noinit_r0_kept", rf2[0], 32'h5A5A_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
